// File: rtl/core6502_pc_pkg.sv
// Shared types and constants for the program counter stage.
package core6502_pc_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      FIX  = 1'b1
   } pc_state_e;

   localparam logic [15:0] PC_RESET_VECTOR = 16'hFFFC;

endpackage

// File: rtl/pc_incr8.sv
// 8-bit incrementer/decrementer with carry (or borrow) out.
module pc_incr8 (
   input  logic [7:0] a,
   input  logic       dec,
   output logic [7:0] y,
   output logic       co
);

   // Single +1/-1 adder; bit 8 is carry on increment, borrow on decrement.
   always_comb begin
      if (dec) begin
         {co, y} = {1'b0, a} - 9'd1;
      end else begin
         {co, y} = {1'b0, a} + 9'd1;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program counter stage feeding the address bus output register.
// Optional relative-branch FSM compiled in with PC_BRANCH_ADD_EN.
//
// state | meaning
// IDLE  | normal operation, accepts increment / branch start
// FIX   | branch crossed a page, PCH is adjusted next edge (busy=1)
module pc_unit
   import core6502_pc_pkg::*;
#(
   parameter logic [15:0] RESET_VECTOR = PC_RESET_VECTOR
) (
   input  logic        PHI0,
   input  logic        RES,
   input  logic [7:0]  ADL_in,
   input  logic [7:0]  ADH_in,
   input  logic        ADL_PCL,
   input  logic        ADH_PCH,
   input  logic        I_PC,
   input  logic        BR_take,
   input  logic [7:0]  BR_off,
   output logic [15:0] PC_ADX,
   output logic        ADX_ABX,
   output logic        PCLC,
   output logic        busy
);

   logic [7:0] pcl_q, pcl_d;
   logic [7:0] pch_q, pch_d;
   logic       adx_q, adx_d;
   logic       pclc_q, pclc_d;

   logic       load;
   logic       in_fix;
   logic       br_go;
   logic [7:0] br_sum;
   logic       br_c;
   logic       pch_dec;
   logic [7:0] pcl_inc;
   logic       pcl_co;
   logic [7:0] pch_step;
   logic       pch_co_unused;

   assign load = ADL_PCL | ADH_PCH;

   pc_incr8 u_pcl_inc (
      .a   (pcl_q),
      .dec (1'b0),
      .y   (pcl_inc),
      .co  (pcl_co)
   );

   // PCH steps up on increment carry or positive fix, down on negative fix.
   pc_incr8 u_pch_step (
      .a   (pch_q),
      .dec (pch_dec),
      .y   (pch_step),
      .co  (pch_co_unused)
   );

`ifdef PC_BRANCH_ADD_EN
   pc_state_e state_q, state_d;
   logic      br_neg_q, br_neg_d;
   logic      page_cross;

   assign in_fix          = (state_q == FIX);
   assign br_go           = BR_take & ~in_fix;
   assign {br_c, br_sum}  = {1'b0, pcl_q} + {1'b0, BR_off};
   assign page_cross      = BR_off[7] ^ br_c;
   assign pch_dec         = in_fix & br_neg_q;
   assign busy            = in_fix;

   // Branch sequencing: a load always wins and cancels any pending fix-up.
   always_comb begin
      state_d  = state_q;
      br_neg_d = br_neg_q;
      if (load) begin
         state_d = IDLE;
      end else if (in_fix) begin
         state_d = IDLE;
      end else if (br_go) begin
         br_neg_d = BR_off[7];
         if (page_cross) begin
            state_d = FIX;
         end
      end
   end

   // Branch FSM registers.
   always_ff @(posedge PHI0) begin
      if (RES) begin
         state_q  <= IDLE;
         br_neg_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         br_neg_q <= br_neg_d;
      end
   end
`else
   logic unused_br;

   assign in_fix    = 1'b0;
   assign br_go     = 1'b0;
   assign br_sum    = pcl_q;
   assign br_c      = 1'b0;
   assign pch_dec   = 1'b0;
   assign busy      = 1'b0;
   assign unused_br = ^{BR_take, BR_off};
`endif

   // Next PC by priority: load, fix-up, branch add, increment.
   always_comb begin
      pcl_d  = pcl_q;
      pch_d  = pch_q;
      pclc_d = pclc_q;
      adx_d  = 1'b0;
      if (load) begin
         if (ADL_PCL) pcl_d = ADL_in;
         if (ADH_PCH) pch_d = ADH_in;
         adx_d = 1'b1;
      end else if (in_fix) begin
         pch_d = pch_step;
         adx_d = 1'b1;
      end else if (br_go) begin
         pcl_d  = br_sum;
         pclc_d = br_c;
         adx_d  = 1'b1;
      end else if (I_PC) begin
         pcl_d  = pcl_inc;
         pclc_d = pcl_co;
         if (pcl_co) pch_d = pch_step;
         adx_d  = 1'b1;
      end
   end

   // PC and strobe registers.
   always_ff @(posedge PHI0) begin
      if (RES) begin
         pcl_q  <= RESET_VECTOR[7:0];
         pch_q  <= RESET_VECTOR[15:8];
         adx_q  <= 1'b0;
         pclc_q <= 1'b0;
      end else begin
         pcl_q  <= pcl_d;
         pch_q  <= pch_d;
         adx_q  <= adx_d;
         pclc_q <= pclc_d;
      end
   end

   assign PC_ADX  = {pch_q, pcl_q};
   assign ADX_ABX = adx_q;
   assign PCLC    = pclc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes expected outputs per cycle,
// a monitor pops and compares after each rising edge.
module tb_pc_unit;

   localparam logic [15:0] RV = 16'hFFFC;

   logic        PHI0 = 1'b0;
   logic        RES = 1'b1;
   logic [7:0]  ADL_in = 8'h00;
   logic [7:0]  ADH_in = 8'h00;
   logic        ADL_PCL = 1'b0;
   logic        ADH_PCH = 1'b0;
   logic        I_PC = 1'b0;
   logic        BR_take = 1'b0;
   logic [7:0]  BR_off = 8'h00;
   logic [15:0] PC_ADX;
   logic        ADX_ABX;
   logic        PCLC;
   logic        busy;

   pc_unit #(.RESET_VECTOR(RV)) dut (
      .PHI0    (PHI0),
      .RES     (RES),
      .ADL_in  (ADL_in),
      .ADH_in  (ADH_in),
      .ADL_PCL (ADL_PCL),
      .ADH_PCH (ADH_PCH),
      .I_PC    (I_PC),
      .BR_take (BR_take),
      .BR_off  (BR_off),
      .PC_ADX  (PC_ADX),
      .ADX_ABX (ADX_ABX),
      .PCLC    (PCLC),
      .busy    (busy)
   );

   always #5 PHI0 = ~PHI0;

   typedef struct packed {
      logic [15:0] pc;
      logic        adx;
      logic        pclc;
      logic        busy;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: PC as a 16-bit number, a pending-fix flag and the final target.
   logic [15:0] m_pc = RV;
   logic [15:0] m_tgt = RV;
   logic        m_pclc = 1'b0;
   logic        m_pend = 1'b0;

   task automatic step(input logic res, input logic lpcl, input logic [7:0] adl,
                       input logic lpch, input logic [7:0] adh,
                       input logic inc, input logic br, input logic [7:0] off);
      exp_t        e;
      logic [8:0]  s;
      logic        adx;
      @(negedge PHI0);
      RES = res; ADL_PCL = lpcl; ADL_in = adl; ADH_PCH = lpch; ADH_in = adh;
      I_PC = inc; BR_take = br; BR_off = off;
      adx = 1'b1;
      if (res) begin
         m_pc = RV; m_pclc = 1'b0; m_pend = 1'b0; adx = 1'b0;
      end else if (lpcl || lpch) begin
         if (lpcl) m_pc[7:0]  = adl;
         if (lpch) m_pc[15:8] = adh;
         m_pend = 1'b0;
      end else if (m_pend) begin
         m_pc   = m_tgt;
         m_pend = 1'b0;
`ifdef PC_BRANCH_ADD_EN
      end else if (br) begin
         s      = {1'b0, m_pc[7:0]} + {1'b0, off};
         m_tgt  = m_pc + {{8{off[7]}}, off};
         m_pclc = s[8];
         m_pend = (m_tgt[15:8] != m_pc[15:8]);
         m_pc   = {m_pc[15:8], s[7:0]};
`endif
      end else if (inc) begin
         m_pclc = (m_pc[7:0] == 8'hFF);
         m_pc   = m_pc + 16'd1;
      end else begin
         adx = 1'b0;
      end
      e.pc = m_pc; e.adx = adx; e.pclc = m_pclc; e.busy = m_pend;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: outputs are valid every cycle once stimulus has started.
   initial begin
      exp_t e;
      forever begin
         @(posedge PHI0);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc_adx",  PC_ADX, e.pc);
            check("adx_abx", {15'd0, ADX_ABX}, {15'd0, e.adx});
            check("pclc",    {15'd0, PCLC},    {15'd0, e.pclc});
            check("busy",    {15'd0, busy},    {15'd0, e.busy});
         end
      end
   end

   initial begin
      logic lpcl, lpch, inc, br, res;
      // reset, then four increments across FFFF -> 0000
      step(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
      step(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00);
      step(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
      // 12FF increment, then load wins over increment
      step(0, 1, 8'hFF, 1, 8'h12, 0, 0, 8'h00);
      step(0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00);
      step(0, 1, 8'h34, 0, 8'h00, 1, 0, 8'h00);
      // branches: no cross, positive cross, negative cross
      step(0, 1, 8'h80, 1, 8'h10, 0, 0, 8'h00);
      step(0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h10);
      step(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
      step(0, 1, 8'hF0, 1, 8'h10, 0, 0, 8'h00);
      step(0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h20);
      step(0, 0, 8'h00, 0, 8'h00, 1, 1, 8'h20);
      step(0, 1, 8'h05, 1, 8'h10, 0, 0, 8'h00);
      step(0, 0, 8'h00, 0, 8'h00, 0, 1, 8'hF0);
      step(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
      // load during fix-up cancels it; reset during fix-up
      step(0, 1, 8'hF0, 1, 8'h10, 0, 0, 8'h00);
      step(0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h20);
      step(0, 0, 8'h00, 1, 8'h77, 0, 0, 8'h00);
      step(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
      step(0, 1, 8'hF0, 1, 8'h10, 0, 0, 8'h00);
      step(0, 0, 8'h00, 0, 8'h00, 0, 1, 8'h20);
      step(1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
      step(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         res  = ($urandom_range(0, 99) < 2);
         lpcl = ($urandom_range(0, 99) < 12);
         lpch = ($urandom_range(0, 99) < 12);
         inc  = ($urandom_range(0, 99) < 50);
         br   = ($urandom_range(0, 99) < 35);
         step(res, lpcl, 8'($urandom), lpch, 8'($urandom), inc, br, 8'($urandom));
      end
      step(0, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
      @(posedge PHI0);
      #3;
      check("queue_drained", 16'(exp_q.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
